// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the MAC tile engine.
// Widths are handled at a fixed maximum so one helper serves every accumulator width.
package mac_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_CLOSE = 2'd2
  } tile_state_e;

  function automatic logic [MAX_W-1:0] ACC_MAX(input int acc_w);
    return (MAX_W'(1) << (acc_w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] ACC_MIN(input int acc_w);
    return ~ACC_MAX(acc_w);
  endfunction

  // acc and prod arrive sign-extended to MAX_W; the caller keeps the low acc_w bits.
  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] acc,
                                             input logic [MAX_W-1:0] prod,
                                             input int               acc_w,
                                             input logic             saturate);
    logic [MAX_W:0] full;
    logic [MAX_W:0] top_bit;
    logic           ovf;
    logic           neg;
    full    = {acc[MAX_W-1], acc} + {prod[MAX_W-1], prod};
    top_bit = (MAX_W+1)'(1) << acc_w;
    ovf     = |((full ^ (full << 1)) & top_bit);
    neg     = |(full & top_bit);
    if (ovf && saturate) begin
      return {1'b1, (neg ? ACC_MIN(acc_w) : ACC_MAX(acc_w))};
    end
    return {ovf, full[MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: stage-1 product register, stage-2 accumulator and sticky overflow.
// All sequencing strobes come from the tile controller.
module mac_lane
  import mac_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    adv_i,
  input  logic                    close_i,
  input  logic                    clear_i,
  input  logic signed [IN_W-1:0]  row_i,
  input  logic signed [IN_W-1:0]  col_i,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    ovf_o
);

  logic signed [2*IN_W-1:0] prod_p1_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic                     ovf_q;
  logic                     ovf_d;
  logic [MAX_W:0]           add_r;

  // ---- stage 1: multiply ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_p1_q <= '0;
    end else if (load_i) begin
      prod_p1_q <= row_i * col_i;
    end
  end

  // ---- stage 2: accumulate ----
  assign add_r = sat_add(MAX_W'(acc_q), MAX_W'(prod_p1_q), ACC_W, (SATURATE != 0));
  assign sum_o = add_r[ACC_W-1:0];
  assign ovf_o = ovf_q | add_r[MAX_W];

  generate
    if (ACC_W < MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^add_r[MAX_W-1:ACC_W];
    end
  endgenerate

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear_i || close_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (adv_i) begin
      acc_d = sum_o;
      ovf_d = ovf_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/mac_vec_tile.sv
// Multi-lane pipelined signed MAC tile: lanes, tile-tracking FSM and result handshake.
// A closing tile hands its sums to the result register and the lanes restart without a bubble.
module mac_vec_tile
  import mac_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int IN_W     = 8,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   en,
  input  logic                   last,
  input  logic [LANES*IN_W-1:0]  row_input,
  input  logic [LANES*IN_W-1:0]  col_input,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] result,
  output logic [LANES-1:0]       overflow
);

  logic                   vld_p1_q, vld_p1_d;
  logic                   last_p1_q, last_p1_d;
  logic                   out_valid_q, out_valid_d;
  logic [LANES*ACC_W-1:0] result_q;
  logic [LANES-1:0]       overflow_q;
  tile_state_e            state_q, state_d;

  logic                   stall;
  logic                   accept;
  logic                   consume;
  logic                   close;
  logic [LANES*ACC_W-1:0] lane_sum;
  logic [LANES-1:0]       lane_ovf;

  // A closing last can only leave stage 1 when the result slot is free or draining.
  always_comb begin
    stall    = vld_p1_q & last_p1_q & out_valid_q & ~out_ready;
    in_ready = ~stall;
    accept   = en & in_ready & ~clear;
    consume  = vld_p1_q & ~stall & ~clear;
    close    = consume & last_p1_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      mac_lane #(
        .IN_W     (IN_W),
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
      ) u_lane (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .adv_i   (consume),
        .close_i (close),
        .clear_i (clear),
        .row_i   (row_input[gi*IN_W +: IN_W]),
        .col_i   (col_input[gi*IN_W +: IN_W]),
        .sum_o   (lane_sum[gi*ACC_W +: ACC_W]),
        .ovf_o   (lane_ovf[gi])
      );
    end
  endgenerate

  // ---- stage 1 control ----
  always_comb begin
    vld_p1_d  = accept;
    last_p1_d = accept & last;
    if (clear) begin
      vld_p1_d  = 1'b0;
      last_p1_d = 1'b0;
    end else if (stall) begin
      vld_p1_d  = vld_p1_q;
      last_p1_d = last_p1_q;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (close) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) state_d = last ? ST_CLOSE : ST_ACC;
        end
        ST_ACC: begin
          if (accept && last) state_d = ST_CLOSE;
        end
        ST_CLOSE: begin
          if (close) begin
            if (accept) state_d = last ? ST_CLOSE : ST_ACC;
            else        state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      out_valid_q <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      vld_p1_q    <= vld_p1_d;
      last_p1_q   <= last_p1_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
    end
  end

  // ---- stage 2: result register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      overflow_q <= '0;
    end else if (close) begin
      result_q   <= lane_sum;
      overflow_q <= lane_ovf;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule
